// File: rtl/dp_stream_bridge_pkg.sv
// Shared types and sizing helpers for the datapath stream bridge.
package dp_bridge_pkg;

   // Bridge control states: collect operands, let the datapath settle, present result.
   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } bridge_state_t;

   localparam int DP_IN_W  = 64;
   localparam int DP_OUT_W = 32;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/dp_stream_bridge_if.sv
// Bundle of the operand stream, datapath operand/result ports and result stream.
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both high. The source holds valid and data stable until
// that edge; the bridge derives its own ready/valid only from registered
// state, so neither side may wait on the other combinationally.
interface dp_stream_bridge_if
   import dp_bridge_pkg::*;
#(
   parameter int IN_W  = DP_IN_W,
   parameter int OUT_W = DP_OUT_W,
   parameter int NIN   = 3
);
   logic                    s_valid;
   logic                    s_ready;
   logic signed [IN_W-1:0]  s_data;
   logic signed [IN_W-1:0]  op [NIN];
   logic signed [OUT_W-1:0] res_x;
   logic signed [OUT_W-1:0] res_z;
   logic                    m_valid;
   logic                    m_ready;
   logic [2*OUT_W-1:0]      m_data;
   logic                    busy;
   bridge_state_t           state;

   // Bridge side.
   modport master (
      input  s_valid, s_data, res_x, res_z, m_ready,
      output s_ready, op, m_valid, m_data, busy, state
   );

   // Fabric and datapath side.
   modport slave (
      output s_valid, s_data, res_x, res_z, m_ready,
      input  s_ready, op, m_valid, m_data, busy, state
   );
endinterface

// File: rtl/dp_stream_bridge_lat_counter.sv
// Up-counter with synchronous clear that stops at TERM and flags it.
module lat_counter #(
   parameter int W    = 2,
   parameter int TERM = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == W'(TERM));

   // Next count: clear wins, otherwise count up and park at the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dp_stream_bridge.sv
// Stream front/back end for a fixed-latency datapath: gathers NIN operand
// words, holds them on the operand ports, waits LAT edges, then returns the
// two captured results as one beat.
module dp_stream_bridge
   import dp_bridge_pkg::*;
#(
   parameter int IN_W  = DP_IN_W,
   parameter int OUT_W = DP_OUT_W,
   parameter int NIN   = 3,
   parameter int LAT   = 2
) (
   input logic               clk,
   input logic               rst,
   dp_stream_bridge_if.master bus
);
   localparam int             IDX_W    = clog2_min1(NIN);
   localparam int             CNT_W    = clog2_min1(LAT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIN - 1);

   bridge_state_t          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic signed [IN_W-1:0] op_q [NIN];
   logic [2*OUT_W-1:0]     m_data_q;
   logic                   load_beat;
   logic                   capture;
   logic                   wait_done;

   // Datapath settle timer: runs only in WAIT, cleared everywhere else.
   lat_counter #(
      .W    (CNT_W),
      .TERM (LAT)
   ) u_lat_counter (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (state_q != WAIT),
      .en_i  (state_q == WAIT),
      .tc_o  (wait_done)
   );

   // Next-state, operand index and capture strobe.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      load_beat = 1'b0;
      capture   = 1'b0;
      case (state_q)
         LOAD: begin
            if (bus.s_valid) begin
               load_beat = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = WAIT;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         WAIT: begin
            if (wait_done) begin
               capture = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (bus.m_ready) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   // Control state and operand index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Operand registers: written only by accepted LOAD beats, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NIN; i++) op_q[i] <= '0;
      end else if (load_beat) begin
         op_q[idx_q] <= bus.s_data;
      end
   end

   // Result register: bit-exact snapshot of both datapath outputs.
   always_ff @(posedge clk) begin
      if (rst)          m_data_q <= '0;
      else if (capture) m_data_q <= {bus.res_x, bus.res_z};
   end

   for (genvar g = 0; g < NIN; g++) begin : g_op
      assign bus.op[g] = op_q[g];
   end

   assign bus.s_ready = (state_q == LOAD);
   assign bus.m_valid = (state_q == OUT);
   assign bus.busy    = (state_q == WAIT) || (state_q == OUT);
   assign bus.m_data  = m_data_q;
   assign bus.state   = state_q;
endmodule

// File: doc/dp_stream_bridge.md
# dp_stream_bridge

- Sequential front/back end for the generated 64-bit signed datapath, which has a fixed register latency.
- On the input side it accepts operands as a valid/ready word stream, one `IN_W` word per beat, and holds them stable on parallel operand ports for the whole computation.
- On the output side it waits the datapath latency, captures the two `OUT_W` results and returns them as one valid/ready result beat.
- It sits between the system stream fabric and any generated datapath with `NIN` inputs and two registered outputs.

## Interface
Parameters:
- `IN_W`, 64: operand word width (signed).
- `OUT_W`, 32: width of each datapath result.
- `NIN`, 3: number of operand words per transaction. Must be ≥ 1.
- `LAT`, 2: clock edges from stable operands to valid datapath outputs. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `s_valid`, in, 1: operand word valid.
- `s_ready`, out, 1: bridge accepts an operand word.
- `s_data`, in, `IN_W`, signed: operand word. Order within a transaction is a, b, c, …
- `op_a`, `op_b`, `op_c`, out, `IN_W` each, signed: held operands to the datapath (`op_c` exists only when `NIN` = 3; generalised as `op[NIN]`).
- `res_x`, `res_z`, in, `OUT_W` each, signed: datapath registered outputs.
- `m_valid`, out, 1: result beat valid.
- `m_ready`, in, 1: downstream accepts the result.
- `m_data`, out, 2·`OUT_W`: `{res_x, res_z}` as captured.
- `busy`, out, 1: high in WAIT and OUT.

## Operation
States: LOAD, WAIT, OUT.

LOAD
- `s_ready` = 1.
- Each `s_valid` & `s_ready` beat writes `s_data` into operand register `idx` and increments `idx`.
- When the beat has `idx` = `NIN`−1: `idx` returns to 0 and the state moves to WAIT with `cnt` = 0.

WAIT
- `s_ready` = 0.
- `cnt` increments each cycle.
- When `cnt` = `LAT`: capture `{res_x, res_z}` into the `m_data` register and go to OUT.

OUT
- `m_valid` = 1.
- `m_data` is stable until the handshake.
- On `m_valid` & `m_ready`: go to LOAD.

Operand registers
- Change only on accepted LOAD beats.
- Stable through WAIT and OUT. The datapath sees constant inputs for at least `LAT`+1 cycles.

Widths
- `idx` is ⌈log2(`NIN`)⌉ bits, minimum 1.
- `cnt` is ⌈log2(`LAT`+1)⌉ bits.
- No arithmetic on data; results pass through bit-exact without sign extension.

## Timing
- Reset values: state = LOAD, `idx` = 0, `cnt` = 0, all operand registers = 0, `m_data` = 0. Outputs: `s_ready` = 1, `m_valid` = 0, `busy` = 0.
- `s_ready` and `m_valid` are decoded from registered state only. There is no combinational path from `s_valid` to `s_ready` or from `m_ready` to `m_valid`.
- Latency: the last operand is accepted at edge E0. The result is captured at edge E0+`LAT`+1, and `m_valid` is high in the cycle after that edge.
- Throughput: one transaction per `NIN`+`LAT`+2 cycles minimum when `m_ready` is held high. `s_ready` rises the cycle after the result handshake.
- `m_ready` low: OUT holds indefinitely with `m_data` unchanged. `s_valid` is ignored because `s_ready` = 0.
- `s_valid` gaps in LOAD: `idx` holds and partial operands are retained.
- `m_ready` asserted before OUT: no effect.
- `rst` in any state, including mid-LOAD or mid-WAIT: the next cycle has reset values. Partial operands and in-flight results are discarded, and no `m_valid` pulse occurs.
- `rst` has priority over a simultaneous handshake on either side.

## Structure
- Package `dp_bridge_pkg` holds:
  - the state enum `bridge_state_t` {LOAD, WAIT, OUT};
  - the default width constants `DP_IN_W` = 64, `DP_OUT_W` = 32;
  - the `clog2_min1` function used for `idx`/`cnt` sizing.
- One sub-module, `lat_counter`: a parameterised up-counter with clear and terminal-count flag, used for `cnt`.
- Operand storage is an `IN_W` × `NIN` register array inside the top module.

## Test plan
All scenarios run with the generated datapath attached as DUT load.
- Reset, then idle: `s_ready` = 1, `m_valid` = 0, `busy` = 0, operand ports = 0.
- Send a = 10, b = 3, c = 5 with `m_ready` = 1:
  - `m_valid` rises exactly `LAT`+1 = 3 cycles after the c handshake;
  - `m_data` = `{32'd30, 32'd15}`.
- Send a = 0, b = 4, c = 4 (equal path):
  - `m_data` = `{32'hFFFFFFFC, 32'h00000002}`.
- Hold `m_ready` = 0 for 10 cycles in OUT while driving `s_valid` = 1 with `s_data` = 99:
  - `m_data` is unchanged and `s_ready` stays 0;
  - the following transaction starts at word a with value 99 only after the result handshake.
- Assert `rst` after b is accepted, then send a = 1, b = 2, c = 3:
  - no stale result appears;
  - `m_data` = `{32'd8, 32'd4}` (d = 3, e = 4, g = h = 4).
- Back-to-back transactions with random `s_valid`/`m_ready` gaps over 1000 iterations against a reference model:
  - every result matches;
  - no beat is dropped or duplicated;
  - `s_ready` and `m_valid` are never high in the same cycle.
